// File: rtl/sigma_delta_adc.sv
// ---------------------------------------------------------------------------
// sigma_delta_adc
//
// 1-bit sigma-delta ADC front end with a sinc3 (third-order CIC) decimator.
// The external comparator output is synchronised, echoed back as the feedback
// bit, and the resulting bitstream is decimated by R = 2**OSR_LOG2 into
// unsigned excess-2**(OUT_W-1) PCM samples.
//
// Parameters
//   OSR_LOG2 : log2 of the decimation ratio R
//   OUT_W    : output sample width, 1 <= OUT_W <= 3*OSR_LOG2
//
// Ports
//   CLK    in   system clock, all flops on the rising edge
//   RESET  in   asynchronous, active-high reset
//   CEN    in   modulator-rate enable, one comparator sample per CEN cycle
//   CMPin  in   raw asynchronous comparator output
//   FBout  out  feedback bit to the external RC integrator
//   DOUT   out  decimated sample, OUT_W bits
//   DVALID out  one-CLK pulse in the cycle DOUT takes a new value
// ---------------------------------------------------------------------------
module sigma_delta_adc #(
    parameter int unsigned OSR_LOG2 = 6,
    parameter int unsigned OUT_W    = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CEN,
    input  logic             CMPin,
    output logic             FBout,
    output logic [OUT_W-1:0] DOUT,
    output logic             DVALID
);

    // Integrator/comb width: full-scale CIC gain is R**3 = 2**(3*OSR_LOG2),
    // which needs one bit above the nominal 3*OSR_LOG2.
    localparam int unsigned W = 3 * OSR_LOG2 + 1;

    localparam logic [OSR_LOG2-1:0] CntOne   = OSR_LOG2'(1);
    localparam logic [OSR_LOG2-1:0] CntLast  = '1;
    localparam logic [1:0]          WarmDone = 2'd3;

    // Synchroniser
    logic cmp_s1;
    logic cmp_s2;

    // Integrators (modular, wrap-around is harmless for a CIC)
    logic [W-1:0] int1_q, int1_d;
    logic [W-1:0] int2_q, int2_d;
    logic [W-1:0] int3_q, int3_d;

    // Comb delay elements
    logic [W-1:0] dly1_q;
    logic [W-1:0] dly2_q;
    logic [W-1:0] dly3_q;
    logic [W-1:0] comb1;
    logic [W-1:0] comb2;
    logic [W-1:0] comb3;

    // Decimation and warmup counters
    logic [OSR_LOG2-1:0] cnt_q;
    logic [1:0]          warm_q;

    logic             boundary;
    logic [W-2:0]     sat;
    logic [OUT_W-1:0] dout_d;
    logic             unused_sat;

    // -----------------------------------------------------------------------
    // Two-flop synchroniser, runs every CLK regardless of CEN
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cmp_s1 <= 1'b0;
            cmp_s2 <= 1'b0;
        end else begin
            cmp_s1 <= CMPin;
            cmp_s2 <= cmp_s1;
        end
    end

    // -----------------------------------------------------------------------
    // Integrator next-state and comb datapath
    // -----------------------------------------------------------------------
    always_comb begin
        int1_d = int1_q + {{(W-1){1'b0}}, cmp_s2};
        int2_d = int2_q + int1_q;
        int3_d = int3_q + int2_q;

        boundary = CEN && (cnt_q == CntLast);

        // Comb input is I3 after this cycle's update.
        comb1 = int3_d - dly1_q;
        comb2 = comb1 - dly2_q;
        comb3 = comb2 - dly3_q;

        // Only full scale reaches the top bit; clamp it to the largest code.
        sat    = comb3[W-1] ? '1 : comb3[W-2:0];
        dout_d = sat[W-2 -: OUT_W];
    end

    // Truncated LSBs of the scaled value are intentionally dropped.
    assign unused_sat = ^sat;

    // -----------------------------------------------------------------------
    // Modulator-rate state: feedback bit, integrators, decimation counter
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            FBout  <= 1'b0;
            int1_q <= '0;
            int2_q <= '0;
            int3_q <= '0;
            cnt_q  <= '0;
        end else if (CEN) begin
            FBout  <= cmp_s2;
            int1_q <= int1_d;
            int2_q <= int2_d;
            int3_q <= int3_d;
            cnt_q  <= cnt_q + CntOne;
        end
    end

    // -----------------------------------------------------------------------
    // Decimated-rate state: comb delays, warmup, output register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dly1_q <= '0;
            dly2_q <= '0;
            dly3_q <= '0;
            warm_q <= '0;
            DOUT   <= '0;
            DVALID <= 1'b0;
        end else begin
            DVALID <= 1'b0;
            if (boundary) begin
                // Delays advance on every boundary so the comb is primed
                // by the time warmup releases the output.
                dly1_q <= int3_d;
                dly2_q <= comb1;
                dly3_q <= comb2;
                if (warm_q == WarmDone) begin
                    DOUT   <= dout_d;
                    DVALID <= 1'b1;
                end else begin
                    warm_q <= warm_q + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sigma_delta_adc.sv
// ---------------------------------------------------------------------------
// tb_sigma_delta_adc
//
// Scoreboard bench for sigma_delta_adc. The stimulus process keeps a record
// of the comparator level at every clock edge and of every bit the modulator
// consumes; at each decimation boundary it evaluates the sinc3 response as a
// direct convolution with the triple-box impulse response and queues the
// expected sample together with the edge it should appear after. A separate
// monitor pops and compares on every DVALID.
// ---------------------------------------------------------------------------
module tb_sigma_delta_adc;

    localparam int unsigned OSR_LOG2 = 6;
    localparam int unsigned OUT_W    = 16;
    localparam int          R        = 1 << OSR_LOG2;
    localparam int          NG       = 3 * R - 2;
    localparam int          SH       = 3 * OSR_LOG2 - OUT_W;
    localparam longint      FULL     = longint'(1) << (3 * OSR_LOG2);

    logic             CLK    = 1'b0;
    logic             RESET  = 1'b1;
    logic             CEN    = 1'b0;
    logic             CMPin  = 1'b0;
    logic             FBout;
    logic [OUT_W-1:0] DOUT;
    logic             DVALID;

    sigma_delta_adc #(
        .OSR_LOG2 (OSR_LOG2),
        .OUT_W    (OUT_W)
    ) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .CEN    (CEN),
        .CMPin  (CMPin),
        .FBout  (FBout),
        .DOUT   (DOUT),
        .DVALID (DVALID)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [OUT_W-1:0] val;
        int               edge_no;
    } exp_t;

    exp_t             exp_q[$];
    int               checks = 0;
    int               errors = 0;
    int               edge_n = 0;
    logic [OUT_W-1:0] last_dout = '0;

    longint g[NG];        // sinc3 impulse response (box * box * box)
    bit     cmp_hist[$];  // comparator level sampled at each edge since reset
    bit     bq[$];        // bits consumed on CEN edges since reset
    bit     fb_exp = 1'b0;

    always @(posedge CLK) edge_n <= edge_n + 1;

    function automatic void build_g();
        longint h2[2*R-1];
        for (int i = 0; i < 2 * R - 1; i++) h2[i] = 0;
        for (int i = 0; i < NG; i++) g[i] = 0;
        for (int i = 0; i < R; i++)
            for (int j = 0; j < R; j++) h2[i+j] += 1;
        for (int i = 0; i < 2 * R - 1; i++)
            for (int k = 0; k < R; k++) g[i+k] += h2[i];
    endfunction

    // Output for the boundary at consumed-bit index t. The integrator chain
    // adds two samples of delay ahead of the comb.
    function automatic logic [OUT_W-1:0] model_out(int t);
        longint y = 0;
        for (int j = 0; j < NG; j++) begin
            int m = t - 2 - j;
            if (m >= 0 && bq[m]) y += g[j];
        end
        if (y >= FULL) y = FULL - 1;
        return OUT_W'(y >>> SH);
    endfunction

    // Monitor: compares DVALID/DOUT against the scoreboard.
    always @(negedge CLK) begin
        if (!RESET) begin
            if (DVALID) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL dvalid_unexpected edge %0d dout %h, none expected",
                             edge_n, DOUT);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (DOUT !== e.val || e.edge_no != edge_n) begin
                        errors++;
                        $display("FAIL sample got %h at edge %0d, want %h at edge %0d",
                                 DOUT, edge_n, e.val, e.edge_no);
                    end
                end
                last_dout = DOUT;
            end else begin
                checks++;
                if (DOUT !== last_dout) begin
                    errors++;
                    $display("FAIL dout_hold got %h want %h", DOUT, last_dout);
                end
                if (exp_q.size() > 0 && exp_q[0].edge_no <= edge_n) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL dvalid_missing got 0 at edge %0d, want %h", edge_n, e.val);
                end
            end
        end
    end

    // One CLK cycle: drive at a falling edge, model the coming rising edge.
    task automatic cycle(input bit cen, input bit cmp);
        int k;
        int t;
        bit b;
        CEN   = cen;
        CMPin = cmp;
        cmp_hist.push_back(cmp);
        k = cmp_hist.size() - 1;
        b = (k >= 2) ? cmp_hist[k-2] : 1'b0;
        if (cen) begin
            fb_exp = b;
            bq.push_back(b);
            t = bq.size() - 1;
            if ((t + 1) % R == 0 && (t + 1) / R >= 4) begin
                exp_t e;
                e.val     = model_out(t);
                e.edge_no = edge_n + 1;
                exp_q.push_back(e);
            end
        end
        @(negedge CLK);
        checks++;
        if (FBout !== fb_exp) begin
            errors++;
            $display("FAIL fbout got %0b want %0b at edge %0d", FBout, fb_exp, edge_n);
        end
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if (DOUT !== '0 || DVALID !== 1'b0 || FBout !== 1'b0) begin
            errors++;
            $display("FAIL %s got dout %h dvalid %0b fbout %0b, want all 0",
                     tag, DOUT, DVALID, FBout);
        end
    endtask

    // Entered and left at a falling edge.
    task automatic reset_dut(input string tag);
        cycle(1'b0, CMPin);
        cycle(1'b0, CMPin);
        RESET = 1'b1;
        CEN   = 1'b0;
        CMPin = 1'b0;
        exp_q.delete();
        cmp_hist.delete();
        bq.delete();
        fb_exp    = 1'b0;
        last_dout = '0;
        #1;
        check_zero(tag);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    // ncen CEN samples with pattern (i % period) < ones, one CEN every cen_div CLKs.
    task automatic run_pattern(input int ncen, input int period, input int ones,
                               input int cen_div);
        for (int i = 0; i < ncen; i++) begin
            bit v;
            v = ((i % period) < ones);
            for (int d = 0; d < cen_div - 1; d++) cycle(1'b0, v);
            cycle(1'b1, v);
        end
    endtask

    task automatic run_random(input int nclk);
        for (int i = 0; i < nclk; i++)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        build_g();
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        check_zero("reset_state");
        RESET = 1'b0;

        run_pattern(6 * R, 1, 1, 1);   // full scale, saturates
        reset_dut("reset_after_ones");
        run_pattern(6 * R, 1, 0, 1);   // zero scale
        reset_dut("reset_after_zeros");
        run_pattern(7 * R, 2, 1, 1);   // density 1/2
        reset_dut("reset_after_half");
        run_pattern(6 * R, 4, 1, 1);   // density 1/4
        reset_dut("reset_after_quarter");
        run_pattern(7 * R, 2, 1, 3);   // density 1/2, CEN every 3rd CLK
        reset_dut("reset_after_gapped");
        run_pattern(6 * R, 4, 1, 1);   // density step 1/4 -> 3/4
        run_pattern(6 * R, 4, 3, 1);
        reset_dut("reset_after_step");
        run_random(8 * R);
        reset_dut("reset_after_random");
        run_pattern(5 * R + 22, 2, 1, 1);
        reset_dut("reset_midstream");  // DOUT is nonzero going in
        run_pattern(150, 2, 1, 1);
        reset_dut("reset_at_150");
        run_pattern(6 * R, 2, 1, 1);

        repeat (4) cycle(1'b0, 1'b0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending, want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
